// File: rtl/spi_xfer_sched.sv
// SPI transfer scheduler: arbitrates two requesters onto one SPI mode-0 master port.
// Define SPI_XFER_SCHED_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module spi_xfer_sched #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [7:0] tx_data0,
   input  logic [7:0] tx_data1,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] gnt_q, gnt_d;
   logic [1:0] done_q, done_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       sclk_q, sclk_d;
   logic       cs_n_q, cs_n_d;
   logic       mosi_q, mosi_d;
   logic       owner_q, owner_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic       win;
   logic       cnt_end;
   logic [7:0] tx_sel;

`ifdef SPI_XFER_SCHED_RR_EN
   logic ptr_q, ptr_d;

   // Contention goes to the pointer's requester; a lone request always wins.
   always_comb begin
      if (req == 2'b11) begin
         win = ptr_q;
      end else begin
         win = ~req[0];
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_d != 2'b00) begin
         ptr_d = ~win;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign win = ~req[0];
`endif

   assign cnt_end = (cnt_q == DIV_LAST);
   assign tx_sel  = win ? tx_data1 : tx_data0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      gnt_d     = 2'b00;
      done_d    = 2'b00;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;
      owner_d   = owner_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      case (state_q)
         IDLE: begin
            // The done cycle is never a grant cycle, so the owner's still-high
            // req is only seen as a fresh request one cycle later.
            if ((req != 2'b00) && (done_q == 2'b00)) begin
               gnt_d   = win ? 2'b10 : 2'b01;
               owner_d = win;
               tx_sh_d = tx_sel;
               mosi_d  = tx_sel[7];
               cs_n_d  = 1'b0;
               cnt_d   = 8'd0;
               bit_d   = 3'd0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_end) begin
               cnt_d   = 8'd0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SHIFT: begin
            if (cnt_end) begin
               cnt_d = 8'd0;
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  rx_sh_d = {rx_sh_q[6:0], miso};
               end else begin
                  sclk_d  = 1'b0;
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  mosi_d  = tx_sh_q[6];
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = HOLD;
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (cnt_end) begin
               cnt_d     = 8'd0;
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               done_d    = owner_q ? 2'b10 : 2'b01;
               rx_data_d = rx_sh_q;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         bit_q     <= 3'd0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         rx_data_q <= 8'd0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         owner_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
         owner_q   <= owner_d;
      end
   end

   // Shift registers are pure datapath; they are always reloaded before use.
   always_ff @(posedge clk) begin
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign busy    = (state_q != IDLE) || (done_q != 2'b00);
   assign sclk    = sclk_q;
   assign cs_n    = cs_n_q;
   assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: constant vector table, hand-written corner sequences and
// randomized transfers checked against a transaction-level arbitration/data model.
module tb_spi_xfer_sched;

   localparam int DIV  = 4;
   localparam int DIV2 = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [7:0] tx0, tx1;
   logic [1:0] gnt, done;
   logic [7:0] rx_data;
   logic       busy, sclk, cs_n, mosi, miso;
   logic       miso_drv;
   int         miso_mode;

   logic [1:0] req2;
   logic [7:0] tx2a, tx2b;
   logic [1:0] gnt2, done2;
   logic [7:0] rx2;
   logic       busy2, sclk2, cs_n2, mosi2;

   int errors = 0;
   int checks = 0;

`ifdef SPI_XFER_SCHED_RR_EN
   logic pref;
`endif

   assign miso = (miso_mode == 0) ? mosi : miso_drv;

   always #5 clk = ~clk;

   spi_xfer_sched #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .req(req), .tx_data0(tx0), .tx_data1(tx1),
      .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
   );

   spi_xfer_sched #(.CLK_DIV(DIV2)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .tx_data0(tx2a), .tx_data1(tx2b),
      .gnt(gnt2), .done(done2), .rx_data(rx2), .busy(busy2),
      .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(mosi2)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
      end
   endtask

   // Arbitration model: a lone requester wins; contention resolved by policy.
   function automatic logic [1:0] pick(input logic [1:0] r);
      if (r == 2'b01 || r == 2'b10) return r;
`ifdef SPI_XFER_SCHED_RR_EN
      return pref ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
   endfunction

   // One complete transfer on dut: requests must already be driven.
   task automatic xfer(input string nm, input logic [1:0] exp_g, input logic [7:0] txb,
                       input logic [7:0] exp_rx, input bit drop_early,
                       input logic [1:0] drop_mask);
      bit         got;
      logic [7:0] mb, pat;
      int         rises, first_r, last_r, bad_cs, bad_done;
      logic       prev_s;
      got = 0;
      pat = exp_rx;
      miso_drv = pat[7];
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge clk);
         if (gnt != 2'b00) got = 1;
      end
      check({nm, " gnt"}, 32'(gnt), 32'(exp_g));
      if (!got) return;
      check({nm, " cs_n@gnt"}, 32'(cs_n), 32'd0);
      check({nm, " busy@gnt"}, 32'(busy), 32'd1);
      check({nm, " mosi@gnt"}, 32'(mosi), 32'(txb[7]));
`ifdef SPI_XFER_SCHED_RR_EN
      pref = (exp_g == 2'b01);
`endif
      tx0 = ~tx0;
      tx1 = ~tx1;
      mb = 8'h00; rises = 0; first_r = -1; last_r = -1; bad_cs = 0; bad_done = 0;
      prev_s = 1'b0;
      for (int c = 1; c <= 18 * DIV; c++) begin
         @(negedge clk);
         if (drop_early && c == 1) req = req & ~exp_g;
         if (sclk && !prev_s) begin
            mb = {mb[6:0], mosi};
            if (first_r < 0) first_r = c;
            last_r = c;
            rises++;
            pat = {pat[6:0], 1'b0};
            miso_drv = pat[7];
         end
         prev_s = sclk;
         if (c < 18 * DIV) begin
            if (cs_n !== 1'b0) bad_cs++;
            if (done !== 2'b00 || gnt !== 2'b00) bad_done++;
         end
      end
      check({nm, " done"}, 32'(done), 32'(exp_g));
      check({nm, " rx_data"}, 32'(rx_data), 32'(exp_rx));
      check({nm, " cs_n@done"}, 32'(cs_n), 32'd1);
      check({nm, " gnt@done"}, 32'(gnt), 32'd0);
      check({nm, " mosi bits"}, 32'(mb), 32'(txb));
      check({nm, " rises"}, 32'(rises), 32'd8);
      check({nm, " first rise"}, 32'(first_r), 32'(2 * DIV));
      check({nm, " last rise"}, 32'(last_r), 32'(16 * DIV));
      check({nm, " cs_n glitch"}, 32'(bad_cs), 32'd0);
      check({nm, " stray pulse"}, 32'(bad_done), 32'd0);
      req = req & ~drop_mask;
      @(negedge clk);
      check({nm, " busy after"}, 32'(busy), 32'd0);
      check({nm, " done after"}, 32'(done), 32'd0);
   endtask

   typedef struct {
      logic [1:0] r;
      logic [7:0] t0, t1;
      int         mode;
      logic [7:0] pat;
      logic [1:0] g;
      logic [7:0] rx;
      bit         early;
   } vec_t;

   vec_t vt[7];

   initial begin
      logic [1:0] exp31[4];
      logic [1:0] g;
      logic [7:0] pat, txb;
      bit         got;
      int         bad, done_at, r1, r2;
      logic       ps;

      vt[0] = '{2'b01, 8'hA5, 8'h00, 0, 8'h00, 2'b01, 8'hA5, 1'b0};
      vt[1] = '{2'b10, 8'h11, 8'h00, 1, 8'hFF, 2'b10, 8'hFF, 1'b0};
      vt[2] = '{2'b10, 8'h00, 8'h5A, 1, 8'h96, 2'b10, 8'h96, 1'b0};
      vt[3] = '{2'b01, 8'hFF, 8'h33, 1, 8'h00, 2'b01, 8'h00, 1'b0};
      vt[4] = '{2'b01, 8'h80, 8'h44, 0, 8'h00, 2'b01, 8'h80, 1'b0};
      vt[5] = '{2'b10, 8'h55, 8'h01, 1, 8'h01, 2'b10, 8'h01, 1'b0};
      vt[6] = '{2'b01, 8'hC3, 8'h7E, 0, 8'h00, 2'b01, 8'hC3, 1'b1};

      rst = 1'b0; req = 2'b00; tx0 = 8'h00; tx1 = 8'h00; miso_mode = 0; miso_drv = 1'b0;
      req2 = 2'b00; tx2a = 8'h00; tx2b = 8'h00;
`ifdef SPI_XFER_SCHED_RR_EN
      pref = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst gnt", 32'(gnt), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst rx_data", 32'(rx_data), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst sclk", 32'(sclk), 32'd0);
      check("rst cs_n", 32'(cs_n), 32'd1);
      check("rst mosi", 32'(mosi), 32'd0);
      check("rst cs_n2", 32'(cs_n2), 32'd1);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         req = vt[i].r; tx0 = vt[i].t0; tx1 = vt[i].t1; miso_mode = vt[i].mode;
         txb = (vt[i].g == 2'b01) ? vt[i].t0 : vt[i].t1;
         xfer($sformatf("vec%0d", i), vt[i].g, txb,
              (vt[i].mode == 0) ? txb : vt[i].pat, vt[i].early, vt[i].g);
      end

      // Both requesters held continuously.
      rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
`ifdef SPI_XFER_SCHED_RR_EN
      pref = 1'b0;
      exp31 = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp31 = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      miso_mode = 0; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         tx0 = 8'h3C; tx1 = 8'hC3;
         txb = (exp31[k] == 2'b01) ? 8'h3C : 8'hC3;
         xfer($sformatf("both%0d", k), exp31[k], txb, txb, 1'b0, (k == 3) ? 2'b11 : 2'b00);
      end

      // Reset in the middle of a transfer.
      req = 2'b01; tx0 = 8'h5A; miso_mode = 0; got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge clk);
         if (gnt != 2'b00) got = 1;
      end
      check("abort gnt", 32'(gnt), 32'd1);
      repeat (30) @(negedge clk);
      check("abort cs_n pre", 32'(cs_n), 32'd0);
      rst = 1'b0; req = 2'b00;
      #1;
      check("abort cs_n", 32'(cs_n), 32'd1);
      check("abort sclk", 32'(sclk), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort rx_data", 32'(rx_data), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
`ifdef SPI_XFER_SCHED_RR_EN
      pref = 1'b0;
`endif
      bad = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done !== 2'b00 || cs_n !== 1'b1) bad++;
      end
      check("abort no done", 32'(bad), 32'd0);
      req = 2'b01; tx0 = 8'h5A;
      xfer("recover", 2'b01, 8'h5A, 8'h5A, 1'b0, 2'b01);

      // Randomized transfers against the model.
      for (int n = 0; n < 30; n++) begin
         do req = 2'($urandom_range(3, 1)); while (req == 2'b00);
         tx0 = 8'($urandom); tx1 = 8'($urandom);
         miso_mode = int'($urandom_range(1, 0));
         pat = 8'($urandom);
         g = pick(req);
         txb = (g == 2'b01) ? tx0 : tx1;
         xfer($sformatf("rnd%0d", n), g, txb, (miso_mode == 0) ? txb : pat,
              1'($urandom_range(1, 0)), 2'b11);
      end

      // Faster divider on the second instance.
      req2 = 2'b01; tx2a = 8'h69; got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge clk);
         if (gnt2 != 2'b00) got = 1;
      end
      check("div2 gnt", 32'(gnt2), 32'd1);
      tx2a = 8'h00;
      done_at = -1; r1 = -1; r2 = -1; ps = 1'b0;
      for (int c = 1; c <= 60 && done_at < 0; c++) begin
         @(negedge clk);
         if (sclk2 && !ps) begin
            if (r1 < 0) r1 = c;
            else if (r2 < 0) r2 = c;
         end
         ps = sclk2;
         if (done2 != 2'b00) begin
            done_at = c;
            check("div2 done", 32'(done2), 32'd1);
            req2 = 2'b00;
         end
      end
      check("div2 latency", 32'(done_at), 32'd36);
      check("div2 first rise", 32'(r1), 32'd4);
      check("div2 period", 32'(r2 - r1), 32'd4);
      check("div2 rx_data", 32'(rx2), 32'h69);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
